// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one combinational ALU among
// NREQ requesters.
//
// A granted request latches its operands into registers. Those registers
// drive the ALU for EXEC_CYCLES cycles. The result and flags are then
// captured and returned on a per-requester response handshake.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   req_valid / req_ready   per-requester request handshake (ready one-hot)
//   req_a, req_b            packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cntrl               packed op codes, requester i at [i*3 +: 3]
//   rsp_valid / rsp_ready   per-requester response handshake (valid one-hot)
//   rsp_result, rsp_flags   captured result and {neg, zero, ovf, carry}
//   rsp_err                 request carried an illegal op code
//   alu_a, alu_b, alu_cntrl registered ALU operands and op
//   alu_result, alu_*       combinational ALU result and flags
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; req_ready is the round-robin grant
// EXEC  | operands held on the ALU while it settles
// RESP  | response held on the bus until the winner accepts it
module alu_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 64,
    parameter int EXEC_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_cntrl,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_cntrl,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_negative,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    input  logic                  alu_carry_out
);

    localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);
    localparam logic [2:0] OP_PASS  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]        cntrl_q, cntrl_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic [3:0]        rsp_flags_q, rsp_flags_d;
    logic              rsp_err_q, rsp_err_d;

    logic              gnt_found;
    logic [PW-1:0]     gnt_idx;
    logic [2:0]        req_op;
    logic              op_legal;
    logic              op_arith;
    int                idx;

    // Round-robin search starting at ptr_q.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && req_valid[idx[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset && state_q == S_IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
    end

    assign req_op   = req_cntrl[int'(gnt_idx)*3 +: 3];
    assign op_legal = !(req_op == 3'b001 || req_op == 3'b111);
    assign op_arith = (cntrl_q == OP_ADD) || (cntrl_q == OP_SUB);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        cntrl_d      = cntrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    gnt_d = gnt_idx;
                    a_d   = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                    b_d   = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                    if (op_legal) begin
                        cntrl_d = req_op;
                        cnt_d   = CNT_LOAD;
                        state_d = S_EXEC;
                    end else begin
                        // Illegal ops never reach the ALU; answer immediately.
                        cntrl_d              = OP_PASS;
                        rsp_result_d         = '0;
                        rsp_flags_d          = '0;
                        rsp_err_d            = 1'b1;
                        rsp_valid_d          = '0;
                        rsp_valid_d[gnt_idx] = 1'b1;
                        state_d              = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d       = alu_result;
                    rsp_flags_d        = {alu_negative, alu_zero,
                                          op_arith & alu_overflow,
                                          op_arith & alu_carry_out};
                    rsp_err_d          = 1'b0;
                    rsp_valid_d        = '0;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rsp_valid_d = '0;
                    ptr_d       = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cntrl_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cntrl_q      <= cntrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_cntrl  = cntrl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level reference model.
module tb_alu_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 64;
    localparam int EC    = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ*3-1:0]     req_cntrl;
    logic [WIDTH-1:0]      rsp_result, alu_a, alu_b, alu_result;
    logic [3:0]            rsp_flags;
    logic                  rsp_err;
    logic [2:0]            alu_cntrl;
    logic                  alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic                  force_vc;
    logic [67:0]           alu_o;

    int tests = 0;
    int fails = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .EXEC_CYCLES(EC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cntrl(req_cntrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result), .alu_negative(alu_negative),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry_out(alu_carry_out)
    );

    // ALU stand-in: {result, negative, zero, overflow, carry}.
    function automatic logic [67:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] op);
        logic [64:0] s;
        logic [63:0] r;
        logic        v, c;
        s = '0; r = '0; v = 1'b0; c = 1'b0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[63:0];
                c = s[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                r = a - b;
                c = (a > b);
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = {4{16'hDEAD}};
        endcase
        return {r, r[63], (r == 64'd0), v, c};
    endfunction

    assign alu_o         = alu_fn(alu_a, alu_b, alu_cntrl);
    assign alu_result    = alu_o[67:4];
    assign alu_negative  = alu_o[3];
    assign alu_zero      = alu_o[2];
    assign alu_overflow  = alu_o[1] | force_vc;
    assign alu_carry_out = alu_o[0] | force_vc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] op);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_cntrl[i*3 +: 3]     = op;
    endtask

    // One full transaction: request with the given valid mask, response held
    // back for 'delay' cycles, then accepted.
    task automatic do_txn(input logic [NREQ-1:0] mask, input int delay);
        int              g, n;
        logic [NREQ-1:0] oh;
        logic [63:0]     a, b, er;
        logic [2:0]      op;
        logic [67:0]     e;
        logic [3:0]      ef;
        logic            legal, arith, ee;
        g = -1;
        for (int k = 0; k < NREQ; k++)
            if (g < 0 && mask[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
        oh = '0;
        oh[g] = 1'b1;
        a  = req_a[g*WIDTH +: WIDTH];
        b  = req_b[g*WIDTH +: WIDTH];
        op = req_cntrl[g*3 +: 3];
        legal = !(op == 3'b001 || op == 3'b111);
        arith = (op == 3'b010 || op == 3'b011);
        e = alu_fn(a, b, op);
        if (legal) begin
            er = e[67:4];
            ef = {e[3], e[2], arith & (e[1] | force_vc), arith & (e[0] | force_vc)};
            ee = 1'b0;
        end else begin
            er = '0; ef = '0; ee = 1'b1;
        end

        req_valid = mask;
        @(negedge clk);
        check("req_ready", 64'(req_ready), 64'(oh));
        @(posedge clk); #1;
        req_valid = '0;

        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (legal) begin
                check("alu_a", alu_a, a);
                check("alu_b", alu_b, b);
                check("alu_cntrl", 64'(alu_cntrl), 64'(op));
            end else begin
                check("alu_cntrl_not_illegal", 64'(alu_cntrl != 3'b111), 64'd1);
            end
        end while (rsp_valid == '0 && n < 20);
        check("latency", 64'(n), legal ? 64'(EC + 1) : 64'd1);
        check("rsp_valid", 64'(rsp_valid), 64'(oh));
        check("rsp_result", rsp_result, er);
        check("rsp_flags", 64'(rsp_flags), 64'(ef));
        check("rsp_err", 64'(rsp_err), 64'(ee));

        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            rsp_ready = NREQ'($urandom) & ~oh;
            req_valid = '1;
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'(oh));
            check("bp_rsp_result", rsp_result, er);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = oh | NREQ'($urandom);
        @(posedge clk); #1;
        rsp_ready = '0;
        ptr_m = (g + 1) % NREQ;
    endtask

    initial begin
        int               gl[$];
        int               cl[$];
        logic [NREQ-1:0]  m;
        logic [63:0]      ra, rb;

        reset = 1'b1; req_valid = '1; rsp_ready = '0;
        req_a = '0; req_b = '0; req_cntrl = '0; force_vc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_result", rsp_result, 64'd0);
        check("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_alu_cntrl", 64'(alu_cntrl), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = '0;

        // Single ADD from requester 0
        set_req(0, 64'd1, 64'd1, 3'b010);
        do_txn(4'b0001, 0);
        // SUB from requester 2: zero result, then wrap to all ones
        set_req(2, 64'd1, 64'd1, 3'b011);
        do_txn(4'b0100, 2);
        set_req(2, 64'd0, 64'd1, 3'b011);
        do_txn(4'b0100, 0);
        // AND with the ALU forcing overflow/carry high
        force_vc = 1'b1;
        set_req(3, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b100);
        do_txn(4'b1000, 1);
        force_vc = 1'b0;
        // Illegal op from requester 1
        set_req(1, 64'h1234, 64'h5678, 3'b111);
        do_txn(4'b0010, 0);
        // Backpressure for 10 cycles with everyone else requesting
        set_req(1, 64'd5, 64'd7, 3'b010);
        do_txn(4'b0010, 10);

        // Reset in the middle of EXEC
        set_req(2, 64'd9, 64'd3, 3'b011);
        req_valid = 4'b0100;
        @(negedge clk);
        check("pre_rst_req_ready", 64'(req_ready), 64'b0100);
        @(posedge clk); #1;
        req_valid = '1;
        reset = 1'b1;
        @(negedge clk);
        check("exec_alu_a", alu_a, 64'd9);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_rsp_result", rsp_result, 64'd0);
        check("mid_rst_rsp_flags", 64'(rsp_flags), 64'd0);
        check("mid_rst_rsp_err", 64'(rsp_err), 64'd0);
        check("mid_rst_alu_a", alu_a, 64'd0);
        check("mid_rst_alu_b", alu_b, 64'd0);
        check("mid_rst_alu_cntrl", 64'(alu_cntrl), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ptr_m = 0;

        // Round robin with all requesters valid and responses always accepted
        for (int i = 0; i < NREQ; i++) set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 3'b010);
        req_valid = '1;
        rsp_ready = '1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) begin gl.push_back(i); cl.push_back(c); end
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        rsp_ready = '0;
        check("rr_grant_count", 64'(gl.size() >= 5), 64'd1);
        for (int i = 0; i < gl.size(); i++) begin
            check("rr_order", 64'(gl[i]), 64'(i % NREQ));
            if (i > 0) check("rr_interval", 64'(cl[i] - cl[i-1]), 64'(EC + 2));
        end
        if (gl.size() > 0) ptr_m = (gl[gl.size()-1] + 1) % NREQ;

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if ($urandom_range(0, 5) == 0) ra = '1;
                if ($urandom_range(0, 5) == 0) rb = (t % 2 == 0) ? 64'd0 : ra;
                set_req(i, ra, rb, 3'($urandom_range(0, 7)));
            end
            m = NREQ'($urandom);
            if (m == '0) m = NREQ'(1) << (t % NREQ);
            force_vc = 1'($urandom_range(0, 1));
            do_txn(m, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 64-bit ALU among NREQ requesters. Arbitration is round-robin.
- Each request (A, B, cntrl) is accepted with a valid/ready handshake and latched into operand registers, which drive the ALU for EXEC_CYCLES cycles.
- After that, result and flags are captured and returned to the winner on a per-requester response handshake.
- Sits between the ALU and its clients: datapath execute stage, address generator, debug port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 64, operand/result width.
- EXEC_CYCLES, 2, cycles the ALU inputs are held stable before capture (1..15); covers ALU settling.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  request pending, one bit per requester.
- req_ready  output  NREQ  one-hot accept; at most one bit high.
- req_a  input  NREQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing.
- req_cntrl  input  NREQ*3  op code; requester i in bits [i*3 +: 3].
- rsp_valid  output  NREQ  one-hot response valid.
- rsp_ready  input  NREQ  requester accepts response.
- rsp_result  output  WIDTH  captured result, shared bus.
- rsp_flags  output  4  {negative, zero, overflow, carry_out}, captured.
- rsp_err  output  1  illegal op code.
- alu_a, alu_b  output  WIDTH  ALU operands, driven from registers.
- alu_cntrl  output  3  ALU op, driven from register.
- alu_result  input  WIDTH  ALU result.
- alu_negative, alu_zero, alu_overflow, alu_carry_out  input  1 each  ALU flags.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; the ports are named clk and reset.
- Legal op codes: 000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR. Illegal: 001, 111.
- FSM states: IDLE, EXEC, RESP.

IDLE:
- Grant g = first i with req_valid[i], scanning ptr, ptr+1, ... modulo NREQ.
- req_ready[g] is combinational from req_valid and ptr, high only in IDLE. The handshake completes in the same cycle.
- On handshake:
  - latch a, b, cntrl, g;
  - clear the counter;
  - go to EXEC.
- No valid requests: stay in IDLE.

EXEC:
- alu_a / alu_b / alu_cntrl are driven from the latched registers and stay stable for the whole state.
- Counter increments each cycle. When counter == EXEC_CYCLES-1:
  - capture alu_result and flags into the rsp registers;
  - go to RESP.
- Illegal op code: skip EXEC. Go directly from IDLE to RESP with result=0, flags=0000, rsp_err=1.
- Flag masking: overflow and carry_out are captured as 0 unless the op is ADD or SUB. negative and zero are always taken from the ALU.

RESP:
- rsp_valid[g]=1; rsp_result / rsp_flags / rsp_err are held.
- On rsp_ready[g]: ptr <= (g+1) mod NREQ, go to IDLE. rsp_ready on other bits is ignored.

Latency and throughput:
- Accept to rsp_valid: EXEC_CYCLES+1 cycles.
- Minimum issue interval: EXEC_CYCLES+2 cycles.

Reset values (also apply when reset is asserted mid-operation):
- state=IDLE, ptr=0.
- rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0.
- Operand and cntrl registers = 0, so alu_cntrl=000.
- req_ready=0 while reset is high.
- A reset mid-EXEC or mid-RESP abandons the in-flight op with no response.

Boundary rules:
- req_valid may drop without a handshake; no grant is lost.
- ptr wraps from NREQ-1 to 0.
- The response bus changes only on the EXEC→RESP or IDLE→RESP transition.

Test Plan:
- Single ADD, requester 0: A=1, B=1, cntrl=010 → req_ready[0] in the same cycle; rsp_valid[0] after 3 cycles; result=2, flags=0000, err=0.
- Round-robin: all 4 valid continuously, rsp_ready tied high → grant order 0,1,2,3,0; every grant is issued every 4 cycles.
- SUB A=1, B=1 from requester 2 → result=0, flags=0100 (zero=1). SUB A=0, B=1 → result=FFFF_FFFF_FFFF_FFFF, negative=1, carry_out=0.
- AND A=FFFF_0000_FFFF_0000, B=0F0F_0F0F_0F0F_0F0F → result=0F0F_0000_0F0F_0000, overflow=0 and carry_out=0 even if forced high by an ALU model.
- Illegal cntrl=111 from requester 1 → rsp_valid[1] one cycle after accept; result=0, err=1; alu_cntrl never shows 111.
- Backpressure and reset: hold rsp_ready=0 for 10 cycles → rsp_valid and result held and no new grant. Then assert reset mid-EXEC → all outputs 0 next cycle and ptr=0.
